slow_clock_monitor: RTL

Receiving-side companion to the simulation clock divider. Samples a divided clock (`slow_clock`) in the fast `clk` domain, emits one-cycle rise/fall ticks, measures period and high time in `clk` cycles, and checks them against the expected divide factor. It is used wherever logic running on `clk` must step in lock with the randomizer/logic clock ratio. It also flags ratio drift or a stalled slow clock.

---
 rtl/slow_clock_monitor.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/slow_clock_monitor.sv
// Observes a divided clock from the fast clk domain: edge ticks, period/high-time
// measurement with a valid/ready output, and lock/mismatch tracking against factor.
module slow_clock_monitor #(
   parameter int N          = 32,
   parameter int LOCK_COUNT = 4
) (
   input  logic         clk,
   input  logic         RESET_SIM_N,
   input  logic         enable,
   input  logic         slow_clock,
   input  logic [N-1:0] factor,
   output logic         rise_tick,
   output logic         fall_tick,
   output logic [N-1:0] period,
   output logic [N-1:0] high_time,
   output logic         meas_valid,
   input  logic         meas_ready,
   output logic         locked,
   output logic         mismatch,
   output logic         overrun
);

   localparam int MW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
   localparam logic [MW-1:0] LOCK_TARGET = MW'(LOCK_COUNT);
   localparam logic [N-1:0]  CNT_MAX     = {N{1'b1}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            s1_q, s2_q, s3_q;
   logic            riseTick_q, fallTick_q;
   logic [N-1:0]    cnt_q, cnt_d;
   logic [N-1:0]    hiCap_q, hiCap_d;
   logic [MW-1:0]   matchCtr_q, matchCtr_d;
   logic [N-1:0]    period_q, period_d;
   logic [N-1:0]    highTime_q, highTime_d;
   logic            measValid_q, measValid_d;
   logic            locked_q, locked_d;
   logic            mismatch_q, mismatch_d;
   logic            overrun_q, overrun_d;

   logic            riseCond;
   logic            fallCond;
   logic            periodMatch;
   logic            timeoutHit;
   logic            capture;
   logic [N:0]      twoFactor;
   logic [N-1:0]    cntInc;
   logic [MW-1:0]   matchInc;

   // The synchronizer and tick registers run regardless of enable, so a tick
   // already in flight when enable drops still shows up.
   always_ff @(posedge clk or negedge RESET_SIM_N) begin
      if (!RESET_SIM_N) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
         riseTick_q <= 1'b0;
         fallTick_q <= 1'b0;
      end else begin
         s1_q       <= slow_clock;
         s2_q       <= s1_q;
         s3_q       <= s2_q;
         riseTick_q <= s2_q & ~s3_q;
         fallTick_q <= ~s2_q & s3_q;
      end
   end

   assign riseCond    = s2_q & ~s3_q;
   assign fallCond    = ~s2_q & s3_q;
   assign twoFactor   = {factor, 1'b0};
   assign periodMatch = (cnt_q == factor) && (hiCap_q == (factor >> 1));
   assign timeoutHit  = (factor > N'(1)) && ({1'b0, cnt_q} >= twoFactor);
   assign capture     = enable && riseCond && (state_q != IDLE);
   assign cntInc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + N'(1);
   assign matchInc    = matchCtr_q + MW'(1);

   always_ff @(posedge clk or negedge RESET_SIM_N) begin
      if (!RESET_SIM_N) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hiCap_q     <= '0;
         matchCtr_q  <= '0;
         period_q    <= '0;
         highTime_q  <= '0;
         measValid_q <= 1'b0;
         locked_q    <= 1'b0;
         mismatch_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hiCap_q     <= hiCap_d;
         matchCtr_q  <= matchCtr_d;
         period_q    <= period_d;
         highTime_q  <= highTime_d;
         measValid_q <= measValid_d;
         locked_q    <= locked_d;
         mismatch_q  <= mismatch_d;
         overrun_q   <= overrun_d;
      end
   end

   // The counter is measured against factor on the rise cycle itself, before it
   // reloads to 1, so a matched divider yields period == factor exactly.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hiCap_d     = hiCap_q;
      matchCtr_d  = matchCtr_q;
      period_d    = period_q;
      highTime_d  = highTime_q;
      measValid_d = measValid_q;
      locked_d    = locked_q;
      mismatch_d  = 1'b0;
      overrun_d   = overrun_q;

      if (fallCond) begin
         hiCap_d = cnt_q;
      end

      if (!enable) begin
         state_d    = IDLE;
         cnt_d      = '0;
         matchCtr_d = '0;
         locked_d   = 1'b0;
         overrun_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               matchCtr_d = '0;
               if (riseCond) begin
                  cnt_d   = N'(1);
                  state_d = ACQUIRE;
               end else begin
                  cnt_d = '0;
               end
            end
            ACQUIRE: begin
               if (riseCond) begin
                  cnt_d = N'(1);
                  if (periodMatch) begin
                     matchCtr_d = matchInc;
                     if (matchInc == LOCK_TARGET) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                     end
                  end else begin
                     matchCtr_d = '0;
                  end
               end else if (timeoutHit) begin
                  mismatch_d = 1'b1;
                  locked_d   = 1'b0;
                  matchCtr_d = '0;
                  cnt_d      = '0;
                  state_d    = IDLE;
               end else begin
                  cnt_d = cntInc;
               end
            end
            LOCKED: begin
               if (riseCond) begin
                  cnt_d = N'(1);
                  if (!periodMatch) begin
                     mismatch_d = 1'b1;
                     locked_d   = 1'b0;
                     matchCtr_d = '0;
                     state_d    = ACQUIRE;
                  end
               end else if (timeoutHit) begin
                  mismatch_d = 1'b1;
                  locked_d   = 1'b0;
                  matchCtr_d = '0;
                  cnt_d      = '0;
                  state_d    = IDLE;
               end else begin
                  cnt_d = cntInc;
               end
            end
            default: begin
               state_d    = IDLE;
               cnt_d      = '0;
               matchCtr_d = '0;
               locked_d   = 1'b0;
            end
         endcase
      end

      // A fresh pair may replace the held one only if the slot is empty or
      // being drained this cycle; otherwise the new pair is lost.
      if (capture) begin
         if (!measValid_q || meas_ready) begin
            period_d    = cnt_q;
            highTime_d  = hiCap_q;
            measValid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (measValid_q && meas_ready) begin
         measValid_d = 1'b0;
      end
   end

   assign rise_tick  = riseTick_q;
   assign fall_tick  = fallTick_q;
   assign period     = period_q;
   assign high_time  = highTime_q;
   assign meas_valid = measValid_q;
   assign locked     = locked_q;
   assign mismatch   = mismatch_q;
   assign overrun    = overrun_q;

endmodule
